// File: rtl/fft_butterfly_scheduler.sv
// -----------------------------------------------------------------------------
// fft_butterfly_scheduler
//
// Sequences a 4-point radix-2 DIT FFT through one shared, external,
// combinational butterfly. The samples are captured in bit-reversed order,
// and then two butterflies are issued per stage. The spectrum is published
// on the FIN cycle together with a one-cycle done pulse.
//
// Ports
//   clk                    rising-edge clock
//   rst                    synchronous, active-high reset (overrides ena)
//   ena                    advance enable; low freezes every register
//   start                  transform request, only looked at in IDLE
//   sample0_in..sample3_in time samples {re[7:0], im[7:0]}, two's complement
//   bf_a, bf_b, bf_tw      operands and twiddle select (0 = 1, 1 = -j) sent
//                          to the external butterfly
//   bf_y0, bf_y1           butterfly results a + W*b, a - W*b
//   freq0_out..freq3_out   registered spectrum X0..X3
//   busy, done             status (busy in S1A..FIN, done pulses after FIN)
//   start_err              sticky "start while busy" flag
//
// Build option
//   FFT_SCHED_START_ERR_EN  when defined, start_err is a sticky register that
//                           is set by any start seen outside IDLE. When it is
//                           not defined, start_err is tied to 0.
// -----------------------------------------------------------------------------
module fft_butterfly_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        start,
    input  logic [15:0] sample0_in,
    input  logic [15:0] sample1_in,
    input  logic [15:0] sample2_in,
    input  logic [15:0] sample3_in,
    output logic [15:0] bf_a,
    output logic [15:0] bf_b,
    output logic        bf_tw,
    input  logic [15:0] bf_y0,
    input  logic [15:0] bf_y1,
    output logic [15:0] freq0_out,
    output logic [15:0] freq1_out,
    output logic [15:0] freq2_out,
    output logic [15:0] freq3_out,
    output logic        busy,
    output logic        done,
    output logic        start_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1A  = 3'd1,
        S1B  = 3'd2,
        S2A  = 3'd3,
        S2B  = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] r0, r1, r2, r3;

    // The butterfly is combinational outside this block. Its operands must
    // therefore come straight from the state and the working registers, so
    // that its results can be written back on the same edge.
    always_comb begin
        bf_a  = 16'h0000;
        bf_b  = 16'h0000;
        bf_tw = 1'b0;
        case (state)
            S1A: begin bf_a = r0; bf_b = r1; end
            S1B: begin bf_a = r2; bf_b = r3; end
            S2A: begin bf_a = r0; bf_b = r2; end
            S2B: begin bf_a = r1; bf_b = r3; bf_tw = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r0        <= 16'h0000;
            r1        <= 16'h0000;
            r2        <= 16'h0000;
            r3        <= 16'h0000;
            freq0_out <= 16'h0000;
            freq1_out <= 16'h0000;
            freq2_out <= 16'h0000;
            freq3_out <= 16'h0000;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // The bit-reversed load makes the output come out in natural order.
                        r0    <= sample0_in;
                        r1    <= sample2_in;
                        r2    <= sample1_in;
                        r3    <= sample3_in;
                        busy  <= 1'b1;
                        state <= S1A;
                    end
                end
                S1A: begin
                    r0    <= bf_y0;
                    r1    <= bf_y1;
                    state <= S1B;
                end
                S1B: begin
                    r2    <= bf_y0;
                    r3    <= bf_y1;
                    state <= S2A;
                end
                S2A: begin
                    r0    <= bf_y0;
                    r2    <= bf_y1;
                    state <= S2B;
                end
                S2B: begin
                    r1    <= bf_y0;
                    r3    <= bf_y1;
                    state <= FIN;
                end
                FIN: begin
                    freq0_out <= r0;
                    freq1_out <= r1;
                    freq2_out <= r2;
                    freq3_out <= r3;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FFT_SCHED_START_ERR_EN
    logic start_err_q;

    always_ff @(posedge clk) begin
        if (rst)
            start_err_q <= 1'b0;
        else if (ena && start && (state != IDLE))
            start_err_q <= 1'b1;
    end

    assign start_err = start_err_q;
`else
    assign start_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fft_butterfly_scheduler
//
// Scoreboard bench for fft_butterfly_scheduler. It models the external
// butterfly. The expected spectrum of each accepted transform is computed as
// a direct 4-point DFT, with every component taken modulo 256. That spectrum
// is queued together with the cycle on which done is due. A monitor pops the
// queue and compares whenever done rises.
// -----------------------------------------------------------------------------
module tb_fft_butterfly_scheduler;

    typedef logic [3:0][15:0] vec_t;
    typedef struct {
        vec_t f;
        int   cyc;
    } exp_t;

`ifdef FFT_SCHED_START_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ena, start;
    logic [15:0] sample0_in, sample1_in, sample2_in, sample3_in;
    logic [15:0] bf_a, bf_b, bf_y0, bf_y1;
    logic        bf_tw;
    logic [15:0] freq0_out, freq1_out, freq2_out, freq3_out;
    logic        busy, done, start_err;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    bit   err_seen = 1'b0;
    exp_t sb[$];

    fft_butterfly_scheduler dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start),
        .sample0_in(sample0_in), .sample1_in(sample1_in),
        .sample2_in(sample2_in), .sample3_in(sample3_in),
        .bf_a(bf_a), .bf_b(bf_b), .bf_tw(bf_tw),
        .bf_y0(bf_y0), .bf_y1(bf_y1),
        .freq0_out(freq0_out), .freq1_out(freq1_out),
        .freq2_out(freq2_out), .freq3_out(freq3_out),
        .busy(busy), .done(done), .start_err(start_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External butterfly: y = a +/- W*b, where W*b = b for tw=0 and (im, -re) for tw=1.
    function automatic logic [15:0] bfly(input logic [15:0] a, input logic [15:0] b,
                                         input logic tw, input bit sub);
        logic [7:0] wr, wi;
        wr = tw ? b[7:0] : b[15:8];
        wi = tw ? 8'(-b[15:8]) : b[7:0];
        if (sub) return {8'(a[15:8] - wr), 8'(a[7:0] - wi)};
        else     return {8'(a[15:8] + wr), 8'(a[7:0] + wi)};
    endfunction

    assign bf_y0 = bfly(bf_a, bf_b, bf_tw, 1'b0);
    assign bf_y1 = bfly(bf_a, bf_b, bf_tw, 1'b1);

    // Direct DFT: X[k] = sum x[n] * (-j)^(n*k), with each component taken mod 256.
    function automatic vec_t dft4(input vec_t x);
        vec_t X;
        int sr, si, ar, ai;
        for (int k = 0; k < 4; k++) begin
            sr = 0; si = 0;
            for (int n = 0; n < 4; n++) begin
                ar = int'($signed(x[n][15:8]));
                ai = int'($signed(x[n][7:0]));
                case ((n * k) % 4)
                    0: begin sr += ar; si += ai; end
                    1: begin sr += ai; si -= ar; end
                    2: begin sr -= ar; si -= ai; end
                    default: begin sr -= ai; si += ar; end
                endcase
            end
            X[k] = {sr[7:0], si[7:0]};
        end
        return X;
    endfunction

    function automatic logic [15:0] csub(input logic [15:0] a, input logic [15:0] b);
        return {8'(a[15:8] - b[15:8]), 8'(a[7:0] - b[7:0])};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic set_samples(input vec_t x);
        sample0_in = x[0]; sample1_in = x[1]; sample2_in = x[2]; sample3_in = x[3];
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 4; i++) v[i] = 16'($urandom);
        return v;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Runs one transform from a negedge in IDLE. The optional actions are a
    // stall in S1A, a restart pulse in S1B, an S2B operand check, and a
    // reset issued in S2A.
    task automatic do_xfer(input vec_t x, input int stall, input bit restart,
                           input bit chk_s2b, input bit dorst);
        exp_t e;
        wait_idle();
        set_samples(x);
        start = 1'b1;
        ena   = 1'b1;
        if (!dorst) begin
            e.f   = dft4(x);
            e.cyc = cyc + 6 + stall;
            sb.push_back(e);
        end
        @(negedge clk);               // S1A
        start = 1'b0;
        if (stall > 0) begin
            ena = 1'b0;
            repeat (stall) @(negedge clk);
            ena = 1'b1;
        end
        @(negedge clk);               // S1B
        if (restart) begin
            set_samples(rand_vec());
            start    = 1'b1;
            err_seen = 1'b1;
        end
        @(negedge clk);               // S2A
        start = 1'b0;
        if (dorst) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_freq", {freq0_out, freq1_out} | {freq2_out, freq3_out}, 32'd0);
            chk("rst_err", 32'(start_err), 32'd0);
            err_seen = 1'b0;
            return;
        end
        @(negedge clk);               // S2B
        if (chk_s2b) begin
            chk("s2b_tw", 32'(bf_tw), 32'd1);
            chk("s2b_a", 32'(bf_a), 32'(csub(x[0], x[2])));
            chk("s2b_b", 32'(bf_b), 32'(csub(x[1], x[3])));
        end
    endtask

    // Scoreboard monitor: compare on every rising edge of done.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                done_prev = 1'b0;
                continue;
            end
            if (done === 1'b1 && done_prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("freq0", 32'(freq0_out), 32'(e.f[0]));
                    chk("freq1", 32'(freq1_out), 32'(e.f[1]));
                    chk("freq2", 32'(freq2_out), 32'(e.f[2]));
                    chk("freq3", 32'(freq3_out), 32'(e.f[3]));
                end
            end
            done_prev = done;
        end
    end

    initial begin
        vec_t x;
        exp_t e;
        int   t0;
        int   n;
        rst = 1'b1; ena = 1'b1; start = 1'b0;
        set_samples('0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_freq01", {freq0_out, freq1_out}, 32'd0);
        chk("reset_freq23", {freq2_out, freq3_out}, 32'd0);
        chk("idle_bf", {bf_a, bf_b}, 32'd0);
        chk("idle_tw", 32'(bf_tw), 32'd0);
        chk("reset_err", 32'(start_err), 32'd0);

        x = '0; x[0] = 16'h0100;
        do_xfer(x, 0, 1'b0, 1'b0, 1'b0);             // impulse
        x = '0; x[1] = 16'h0100;
        do_xfer(x, 0, 1'b0, 1'b0, 1'b0);             // shifted impulse
        x = {4{16'h0100}};
        do_xfer(x, 0, 1'b0, 1'b1, 1'b0);             // DC with S2B operand check
        x = '0; x[1] = 16'h0100;
        do_xfer(x, 3, 1'b0, 1'b0, 1'b0);             // stall in S1A
        do_xfer(rand_vec(), 0, 1'b1, 1'b1, 1'b0);    // restart ignored
        wait_idle();
        chk("start_err_sticky", 32'(start_err), 32'(ERR_EN & err_seen));

        for (int i = 0; i < 8; i++)
            do_xfer(rand_vec(), int'($urandom_range(0, 2)), 1'b0, 1'b1, 1'b0);

        // Back-to-back: start held high through two transforms.
        wait_idle();
        x = rand_vec();
        set_samples(x);
        start = 1'b1;
        t0 = cyc;
        e.f = dft4(x); e.cyc = t0 + 6;  sb.push_back(e);
        @(negedge clk);
        x = rand_vec();
        set_samples(x);
        err_seen = 1'b1;
        e.f = dft4(x); e.cyc = t0 + 12; sb.push_back(e);
        n = 0;
        while (cyc < t0 + 7 && n < 20) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        wait_idle();
        chk("b2b_start_err", 32'(start_err), 32'(ERR_EN & err_seen));

        do_xfer(rand_vec(), 0, 1'b0, 1'b0, 1'b1);    // reset in S2A
        repeat (10) @(negedge clk);
        chk("post_rst_freq", {freq0_out, freq3_out}, 32'd0);

        do_xfer(rand_vec(), 0, 1'b0, 1'b1, 1'b0);    // first start after reset

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_butterfly_scheduler.md
FFT_BUTTERFLY_SCHEDULER -- requirements
Module: fft_butterfly_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: ena  input  1  advance enable; when low, all state holds.
REQ-004 SHALL have port: start  input  1  request transform; sampled only in IDLE.
REQ-005 SHALL have ports: sample0_in..sample3_in  input  16 each  time samples, {re[7:0], im[7:0]}, signed two's complement.
REQ-006 SHALL have ports: bf_a, bf_b  output  16 each  operands to the shared external combinational butterfly.
REQ-007 SHALL have port: bf_tw  output  1  twiddle select, 0 = W^0 (1), 1 = W^1 (-j).
REQ-008 SHALL have ports: bf_y0, bf_y1  input  16 each  butterfly results, y0 = a + W*b, y1 = a - W*b, per byte, wrapping 8-bit.
REQ-009 SHALL have ports: freq0_out..freq3_out  output  16 each  registered spectrum X0..X3.
REQ-010 SHALL have ports: busy, done  output  1 each  status.
REQ-011 SHALL have port: start_err  output  1  sticky error (see Configuration).

Function
REQ-012 SHALL implement states IDLE, S1A, S1B, S2A, S2B, FIN. Advance one state per clk edge with ena=1.
REQ-013 In IDLE with start=1 and ena=1, SHALL capture the samples into r0..r3 in bit-reversed order (r0=x0, r1=x2, r2=x1, r3=x3) and go to S1A.
REQ-014 S1A SHALL drive a=r0, b=r1, tw=0, and write y0->r0, y1->r1. Next state S1B.
REQ-015 S1B SHALL drive a=r2, b=r3, tw=0, and write y0->r2, y1->r3. Next state S2A.
REQ-016 S2A SHALL drive a=r0, b=r2, tw=0, and write y0->r0, y1->r2. Next state S2B.
REQ-017 S2B SHALL drive a=r1, b=r3, tw=1, and write y0->r1, y1->r3. Next state FIN.
REQ-018 FIN SHALL copy r0..r3 to freq0..freq3_out, pulse done high for exactly one cycle, and return to IDLE.
REQ-019 Latency: start accepted at edge N -> done high during the cycle after edge N+5. freq outputs update at edge N+5.
REQ-020 busy SHALL be high in S1A..FIN and low in IDLE.
REQ-021 freq outputs SHALL hold their last value until the next FIN.
REQ-022 In IDLE and FIN, bf_a, bf_b and bf_tw SHALL be 0.
REQ-023 start while busy SHALL be ignored; the transform in flight SHALL complete unaltered.
REQ-024 ena=0 SHALL freeze state, registers and outputs. done SHALL stay high while frozen in the done cycle.
REQ-025 start held high continuously SHALL launch back-to-back transforms: IDLE re-accepts on the edge after FIN.

Reset
REQ-026 rst at any clock edge, including mid-transform, SHALL force IDLE and clear r0..r3, freq0..freq3_out, busy, done and start_err to 0; rst SHALL override ena.
REQ-027 The first start after reset release SHALL behave per REQ-013.

Configuration
REQ-028 Macro FFT_SCHED_START_ERR_EN defined: start_err SHALL set on any edge with ena=1, start=1 and the state not IDLE, and SHALL remain set until rst.
REQ-029 Macro undefined: start_err SHALL be constant 0 and no error register SHALL be synthesised; all other behaviour is identical.

Verification
REQ-030 Impulse: x0=16'h0100, others 0 -> freq0..3 = 16'h0100 each; done is a single pulse 6 edges after start.
REQ-031 Shifted impulse: x1=16'h0100, others 0 -> freq = 16'h0100, 16'h00FF, 16'hFF00, 16'h0001.
REQ-032 DC: all x=16'h0100 -> freq0=16'h0400, freq1..3=16'h0000; during S2B, bf_tw=1 and bf_a/bf_b equal r1/r3.
REQ-033 Restart: start pulsed during S1B -> result unchanged, no second done; with FFT_SCHED_START_ERR_EN, start_err=1 until rst.
REQ-034 Reset mid-operation: rst asserted in S2A -> next cycle busy=0, done=0, freq=0; no done follows.
REQ-035 Stall: ena=0 for 3 cycles during S1A -> done is delayed by exactly 3 cycles, with results per REQ-031.
